// File: rtl/l1_refill_initiator.sv
// l1_refill_initiator
// Cache-side initiator for the L1-to-L2 read channel. A miss from the L1
// controller becomes one burst word address on the L2 address channel. The
// block then collects BLOCK_WORDS beats into a line buffer, flags the missed
// (critical) word, and hands the complete line back to the cache.
//
// Optional build macro: L1_REFILL_CRITICAL_WORD_FIRST_EN
//   defined   - the burst starts at the missed word. L2 returns the beats in
//               wrapping order, so the first beat is the critical word.
//   undefined - the burst starts at the line base and the beats arrive in
//               sequential order.
//
// Ports:
//   CLK, RST                 clock (rising edge); async active-high reset
//   MISS_VALID/READY         refill request handshake from the cache
//   MISS_ADDRESS             word address of the missed word
//   ADDRESS_TO_L2_VALID/READY, ADDRESS_TO_L2
//                            burst start address to L2
//   DATA_FROM_L2_VALID/READY, DATA_FROM_L2
//                            data beats from L2
//   CRITICAL_VALID           one-cycle pulse: CRITICAL_WORD updated
//   CRITICAL_WORD            missed word, held until the next one arrives
//   FILL_VALID/READY         completed line handshake to the cache
//   FILL_ADDRESS, FILL_LINE  line base word address and line contents
//   BUSY                     high whenever not idle
module l1_refill_initiator #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int L2_BUS_WIDTH  = 32,
  parameter int BLOCK_WORDS   = 8
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic                                  MISS_VALID,
  output logic                                  MISS_READY,
  input  logic [ADDRESS_WIDTH-3:0]              MISS_ADDRESS,
  output logic                                  ADDRESS_TO_L2_VALID,
  input  logic                                  ADDRESS_TO_L2_READY,
  output logic [ADDRESS_WIDTH-3:0]              ADDRESS_TO_L2,
  input  logic                                  DATA_FROM_L2_VALID,
  output logic                                  DATA_FROM_L2_READY,
  input  logic [L2_BUS_WIDTH-1:0]               DATA_FROM_L2,
  output logic                                  CRITICAL_VALID,
  output logic [L2_BUS_WIDTH-1:0]               CRITICAL_WORD,
  output logic                                  FILL_VALID,
  input  logic                                  FILL_READY,
  output logic [ADDRESS_WIDTH-3:0]              FILL_ADDRESS,
  output logic [L2_BUS_WIDTH*BLOCK_WORDS-1:0]   FILL_LINE,
  output logic                                  BUSY
);

  localparam int WAW = ADDRESS_WIDTH - 2;
  localparam int IW  = $clog2(BLOCK_WORDS);
  localparam int LW  = L2_BUS_WIDTH * BLOCK_WORDS;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, FILL} state_t;

  state_t state, state_next;

  logic [WAW-1:0]          l2_address_q;
  logic [WAW-1:0]          line_base_q;
  logic [IW-1:0]           crit_idx_q;
  logic [IW-1:0]           beat_cnt_q;
  logic [LW-1:0]           line_q;
  logic [L2_BUS_WIDTH-1:0] crit_word_q;
  logic                    crit_valid_q;

  logic           accept_miss;
  logic           addr_fire;
  logic           beat_fire;
  logic           last_beat;
  logic [IW-1:0]  start_idx;
  logic [IW-1:0]  write_idx;
  logic [IW-1:0]  miss_idx;
  logic [WAW-1:0] miss_base;

  assign accept_miss = (state == IDLE) && MISS_VALID;
  assign addr_fire   = (state == ADDR) && ADDRESS_TO_L2_READY;
  assign beat_fire   = (state == DATA) && DATA_FROM_L2_VALID;
  assign last_beat   = beat_fire && (beat_cnt_q == IW'(BLOCK_WORDS - 1));
  assign miss_idx    = MISS_ADDRESS[IW-1:0];
  assign miss_base   = {MISS_ADDRESS[WAW-1:IW], {IW{1'b0}}};

  // In the wrapping build the first beat belongs to the missed word, so the
  // start index is the critical index. In the sequential build it is the
  // line base. The IW-bit sum wraps modulo BLOCK_WORDS on its own.
`ifdef L1_REFILL_CRITICAL_WORD_FIRST_EN
  assign start_idx = crit_idx_q;
`else
  assign start_idx = '0;
`endif
  assign write_idx = start_idx + beat_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (MISS_VALID)          state_next = ADDR;
      ADDR:    if (ADDRESS_TO_L2_READY) state_next = DATA;
      DATA:    if (last_beat)           state_next = FILL;
      FILL:    if (FILL_READY)          state_next = IDLE;
      default:                          state_next = IDLE;
    endcase
  end

  // Datapath. Reset wipes everything so that an aborted burst leaves no
  // partial line, address or critical word behind.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      l2_address_q <= '0;
      line_base_q  <= '0;
      crit_idx_q   <= '0;
      beat_cnt_q   <= '0;
      line_q       <= '0;
      crit_word_q  <= '0;
      crit_valid_q <= 1'b0;
    end else begin
      if (accept_miss) begin
        line_base_q <= miss_base;
        crit_idx_q  <= miss_idx;
`ifdef L1_REFILL_CRITICAL_WORD_FIRST_EN
        l2_address_q <= MISS_ADDRESS;
`else
        l2_address_q <= miss_base;
`endif
      end
      if (addr_fire) beat_cnt_q <= '0;
      if (beat_fire) begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
        for (int i = 0; i < BLOCK_WORDS; i++) begin
          if (write_idx == IW'(i)) line_q[i*L2_BUS_WIDTH +: L2_BUS_WIDTH] <= DATA_FROM_L2;
        end
        if (write_idx == crit_idx_q) crit_word_q <= DATA_FROM_L2;
      end
      crit_valid_q <= beat_fire && (write_idx == crit_idx_q);
    end
  end

  assign MISS_READY          = (state == IDLE);
  assign ADDRESS_TO_L2_VALID = (state == ADDR);
  assign DATA_FROM_L2_READY  = (state == DATA);
  assign FILL_VALID          = (state == FILL);
  assign BUSY                = (state != IDLE);
  assign ADDRESS_TO_L2       = l2_address_q;
  assign FILL_ADDRESS        = line_base_q;
  assign FILL_LINE           = line_q;
  assign CRITICAL_WORD       = crit_word_q;
  assign CRITICAL_VALID      = crit_valid_q;

endmodule

// File: tb/tb_l1_refill_initiator.sv
// tb_l1_refill_initiator
// Directed bench for l1_refill_initiator with default parameters (30-bit word
// addresses, 32-bit beats, 8-word lines). Stimulus tasks push the expected
// L2 address, critical word and filled line into queues. A monitor on the
// falling edge pops and compares them whenever the DUT presents the
// corresponding handshake or pulse.
module tb_l1_refill_initiator;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int BW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            miss_valid;
  logic            miss_ready;
  logic [AW-1:0]   miss_address;
  logic            addr_valid;
  logic            addr_ready;
  logic [AW-1:0]   addr_to_l2;
  logic            data_valid;
  logic            data_ready;
  logic [DW-1:0]   data_from_l2;
  logic            crit_valid;
  logic [DW-1:0]   crit_word;
  logic            fill_valid;
  logic            fill_ready;
  logic [AW-1:0]   fill_address;
  logic [DW*BW-1:0] fill_line;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [AW-1:0]    exp_addr_q[$];
  logic [DW-1:0]    exp_crit_q[$];
  int               exp_ord_q[$];
  logic [DW*BW-1:0] exp_line_q[$];
  logic [AW-1:0]    exp_base_q[$];
  logic [DW*BW-1:0] prev_line;

  l1_refill_initiator dut (
    .CLK                 (clk),
    .RST                 (rst),
    .MISS_VALID          (miss_valid),
    .MISS_READY          (miss_ready),
    .MISS_ADDRESS        (miss_address),
    .ADDRESS_TO_L2_VALID (addr_valid),
    .ADDRESS_TO_L2_READY (addr_ready),
    .ADDRESS_TO_L2       (addr_to_l2),
    .DATA_FROM_L2_VALID  (data_valid),
    .DATA_FROM_L2_READY  (data_ready),
    .DATA_FROM_L2        (data_from_l2),
    .CRITICAL_VALID      (crit_valid),
    .CRITICAL_WORD       (crit_word),
    .FILL_VALID          (fill_valid),
    .FILL_READY          (fill_ready),
    .FILL_ADDRESS        (fill_address),
    .FILL_LINE           (fill_line),
    .BUSY                (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got no handshake, required handshake within bound", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor. The beat counter gives each critical pulse its
  // position within the burst.
  int  beats_seen = 0;
  bit  prev_crit = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (addr_valid && addr_ready) begin
        if (exp_addr_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL l2_address: got unexpected %h, required none", addr_to_l2);
        end else checkOutput("l2_address", addr_to_l2, exp_addr_q.pop_front());
        beats_seen = 0;
      end
      if (crit_valid) begin
        if (exp_crit_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL critical_word: got unexpected pulse %h, required none", crit_word);
        end else begin
          checkOutput("critical_word", crit_word, exp_crit_q.pop_front());
          checkOutput("critical_beat_position", beats_seen, exp_ord_q.pop_front());
        end
      end
      if (prev_crit && crit_valid) begin
        checks++; errors++;
        $display("[TB] FAIL critical_pulse_width: got 2+ cycles, required 1");
      end
      prev_crit = crit_valid;
      if (data_valid && data_ready) beats_seen++;
      if (fill_valid && fill_ready) begin
        if (exp_line_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL fill_line: got unexpected fill, required none");
        end else begin
          checkOutput("fill_line", fill_line, exp_line_q.pop_front());
          checkOutput("fill_address", fill_address, exp_base_q.pop_front());
        end
      end
    end else prev_crit = 1'b0;
  end

  // One complete refill. exp_base and crit are hand-computed from addr.
  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [AW-1:0] exp_base,
                               input int crit, input logic [DW-1:0] dbase,
                               input int addr_stall, input bit toggle, input int fill_stall,
                               input bit zero_wait, input bit spurious);
    int start;
    int ord;
    int acc_cyc;
    bit acc;
    bit ok;
    logic [AW-1:0]    ea;
    logic [DW*BW-1:0] line;
`ifdef L1_REFILL_CRITICAL_WORD_FIRST_EN
    start = crit;
    ea = addr;
`else
    start = 0;
    ea = exp_base;
`endif
    line = '0;
    for (int k = 0; k < BW; k++) line[((start + k) % BW)*DW +: DW] = dbase + DW'(k);
    ord = ((crit - start + BW) % BW) + 1;
    exp_addr_q.push_back(ea);
    exp_crit_q.push_back(dbase + DW'(ord - 1));
    exp_ord_q.push_back(ord);
    exp_line_q.push_back(line);
    exp_base_q.push_back(exp_base);

    miss_valid = 1'b1;
    miss_address = addr;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      acc = miss_ready;
      step();
      if (acc) ok = 1'b1;
    end
    acc_cyc = cyc;
    miss_valid = 1'b0;
    miss_address = '0;
    if (!ok) timeoutFail("miss_accept");
    checkOutput("addr_valid_after_miss", addr_valid, 1);

    for (int i = 0; i < addr_stall; i++) begin
      addr_ready = 1'b0;
      if (spurious) begin
        data_valid = 1'b1;
        data_from_l2 = 32'hDEAD;
      end
      step();
      checkOutput("addr_stable", addr_to_l2, ea);
      checkOutput("addr_valid_held", addr_valid, 1);
      checkOutput("data_ready_in_addr", data_ready, 0);
      checkOutput("line_unchanged_in_addr", fill_line, prev_line);
    end
    data_valid = 1'b0;
    addr_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      acc = addr_valid;
      step();
      if (acc) ok = 1'b1;
    end
    addr_ready = 1'b0;
    if (!ok) timeoutFail("addr_handshake");

    for (int k = 0; k < BW; k++) begin
      if (toggle) begin
        data_valid = 1'b0;
        data_from_l2 = 32'hDEAD;
        step();
      end
      data_valid = 1'b1;
      data_from_l2 = dbase + DW'(k);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
        acc = data_ready;
        if (acc) checkOutput("fill_before_last_beat", fill_valid, 0);
        step();
        if (acc) ok = 1'b1;
      end
      if (!ok) timeoutFail("data_beat");
    end
    data_valid = 1'b0;
    checkOutput("fill_valid_after_last", fill_valid, 1);
    if (zero_wait) checkOutput("miss_to_fill_latency", cyc + 1 - acc_cyc, BW + 2);

    for (int i = 0; i < fill_stall; i++) begin
      fill_ready = 1'b0;
      miss_valid = 1'b1;
      miss_address = 30'h99;
      step();
      checkOutput("fill_line_stable", fill_line, line);
      checkOutput("fill_address_stable", fill_address, exp_base);
      checkOutput("fill_valid_held", fill_valid, 1);
      checkOutput("miss_ready_in_fill", miss_ready, 0);
    end
    fill_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      acc = fill_valid;
      step();
      if (acc) ok = 1'b1;
    end
    fill_ready = 1'b0;
    miss_valid = 1'b0;
    miss_address = '0;
    if (!ok) timeoutFail("fill_handshake");
    checkOutput("miss_ready_after_fill", miss_ready, 1);
    checkOutput("busy_after_fill", busy, 0);
    checkOutput("critical_pulse_seen", exp_crit_q.size(), 0);
    prev_line = line;
  endtask

  // Miss at 0x25 (critical index 5), reset after three beats.
  task automatic resetMidBurst();
    bit acc;
    bit ok;
`ifdef L1_REFILL_CRITICAL_WORD_FIRST_EN
    exp_addr_q.push_back(30'h25);
    exp_crit_q.push_back(32'hF0);
    exp_ord_q.push_back(1);
`else
    exp_addr_q.push_back(30'h20);
`endif
    miss_valid = 1'b1;
    miss_address = 30'h25;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      acc = miss_ready;
      step();
      if (acc) ok = 1'b1;
    end
    miss_valid = 1'b0;
    if (!ok) timeoutFail("reset_test_miss");
    addr_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      acc = addr_valid;
      step();
      if (acc) ok = 1'b1;
    end
    addr_ready = 1'b0;
    if (!ok) timeoutFail("reset_test_addr");
    for (int k = 0; k < 3; k++) begin
      data_valid = 1'b1;
      data_from_l2 = 32'hF0 + DW'(k);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
        acc = data_ready;
        step();
        if (acc) ok = 1'b1;
      end
      if (!ok) timeoutFail("reset_test_beat");
    end
    data_from_l2 = 32'hF3;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_fill_line", fill_line, 0);
    checkOutput("reset_miss_ready", miss_ready, 1);
    checkOutput("reset_data_ready", data_ready, 0);
    checkOutput("reset_addr_to_l2", addr_to_l2, 0);
    checkOutput("reset_critical_word", crit_word, 0);
    checkOutput("reset_fill_address", fill_address, 0);
    step();
    step();
    rst = 1'b0;
    step();
    checkOutput("post_reset_data_ready", data_ready, 0);
    checkOutput("post_reset_busy", busy, 0);
    checkOutput("post_reset_line", fill_line, 0);
    checkOutput("reset_test_queue_empty", exp_crit_q.size() + exp_addr_q.size(), 0);
    data_valid = 1'b0;
    prev_line = '0;
  endtask

  initial begin
    rst = 1'b1;
    miss_valid = 1'b0;
    miss_address = '0;
    addr_ready = 1'b0;
    data_valid = 1'b0;
    data_from_l2 = '0;
    fill_ready = 1'b0;
    prev_line = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state_miss_ready", miss_ready, 1);
    checkOutput("reset_state_busy", busy, 0);
    checkOutput("reset_state_addr_valid", addr_valid, 0);
    checkOutput("reset_state_addr", addr_to_l2, 0);
    checkOutput("reset_state_data_ready", data_ready, 0);
    checkOutput("reset_state_crit_valid", crit_valid, 0);
    checkOutput("reset_state_crit_word", crit_word, 0);
    checkOutput("reset_state_fill_valid", fill_valid, 0);
    checkOutput("reset_state_fill_line", fill_line, 0);
    checkOutput("reset_state_fill_address", fill_address, 0);
    rst = 1'b0;
    step();

    data_valid = 1'b1;
    data_from_l2 = 32'hDEAD;
    step();
    checkOutput("idle_data_ready", data_ready, 0);
    step();
    checkOutput("idle_line_unchanged", fill_line, 0);
    checkOutput("idle_still_ready", miss_ready, 1);
    data_valid = 1'b0;

    applyStimulus(30'h13, 30'h10, 3, 32'hA0, 0, 1'b0, 0, 1'b1, 1'b0);
`ifdef L1_REFILL_CRITICAL_WORD_FIRST_EN
    checkOutput("zero_wait_critical_word", crit_word, 32'hA0);
    checkOutput("zero_wait_line_word0", fill_line[31:0], 32'hA5);
`else
    checkOutput("zero_wait_critical_word", crit_word, 32'hA3);
    checkOutput("zero_wait_line_word0", fill_line[31:0], 32'hA0);
`endif

    applyStimulus(30'h2C, 30'h28, 4, 32'hB0, 5, 1'b1, 0, 1'b0, 1'b1);
    applyStimulus(30'h41, 30'h40, 1, 32'hC0, 0, 1'b0, 4, 1'b0, 1'b0);
    resetMidBurst();
    applyStimulus(30'h57, 30'h50, 7, 32'hD0, 0, 1'b0, 0, 1'b1, 1'b0);
    applyStimulus(30'h3FFFFFFF, 30'h3FFFFFF8, 7, 32'hE0, 2, 1'b1, 2, 1'b0, 1'b1);

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l1_refill_initiator.md
# l1_refill_initiator

Cache-side initiator for the L1-to-L2 read channel: accepts a miss request from an L1 cache controller, issues one burst word address to L2 over the valid/ready address channel, collects `BLOCK_WORDS` data beats over the valid/ready data channel into a line buffer, and hands the complete line back to the cache.

- It sits between the L1 instruction or data cache tag/array logic and the L2 read ports (`ADDRESS_TO_L2_*`, `DATA_FROM_L2_*`).
- It is the processor-side counterpart of the L2 responder that drives those ports.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 32, byte address width; word addresses are `ADDRESS_WIDTH-2` bits.
- `L2_BUS_WIDTH`, 32, data beat width.
- `BLOCK_WORDS`, 8, beats per line; power of two, ≥2.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `MISS_VALID`  in  1  cache requests a refill.
- `MISS_READY`  out  1  initiator idle, miss can be accepted.
- `MISS_ADDRESS`  in  `ADDRESS_WIDTH-2`  word address of missed word.
- `ADDRESS_TO_L2_VALID`  out  1  burst address valid.
- `ADDRESS_TO_L2_READY`  in  1  L2 accepts address.
- `ADDRESS_TO_L2`  out  `ADDRESS_WIDTH-2`  burst start word address.
- `DATA_FROM_L2_VALID`  in  1  L2 beat valid.
- `DATA_FROM_L2_READY`  out  1  initiator accepts beat.
- `DATA_FROM_L2`  in  `L2_BUS_WIDTH`  beat data.
- `CRITICAL_VALID`  out  1  one-cycle pulse: missed word available.
- `CRITICAL_WORD`  out  `L2_BUS_WIDTH`  missed word, held until next miss.
- `FILL_VALID`  out  1  complete line available.
- `FILL_READY`  in  1  cache consumes line.
- `FILL_ADDRESS`  out  `ADDRESS_WIDTH-2`  line base word address (low log2(`BLOCK_WORDS`) bits zero).
- `FILL_LINE`  out  `L2_BUS_WIDTH*BLOCK_WORDS`  line; word i at bits [i*L2_BUS_WIDTH +: L2_BUS_WIDTH].
- `BUSY`  out  1  high in any state other than IDLE.

## Operation
FSM states: IDLE, ADDR, DATA, FILL.

- **IDLE:** `MISS_READY`=1. When `MISS_VALID` is high:
  - Register `MISS_ADDRESS`.
  - Set the line base to `MISS_ADDRESS` with low bits cleared.
  - Set the critical index to the low log2(`BLOCK_WORDS`) bits of `MISS_ADDRESS`.
  - Go to ADDR.
- **ADDR:** `ADDRESS_TO_L2_VALID`=1 with the start address held stable (see Configuration). On `ADDRESS_TO_L2_READY`, clear the beat counter and go to DATA.
- **DATA:** `DATA_FROM_L2_READY`=1.
  - Each beat with `DATA_FROM_L2_VALID`=1 is written to line index (start index + beat count) mod `BLOCK_WORDS`; the index wraps naturally within the counter width.
  - The beat whose index equals the critical index is also copied to `CRITICAL_WORD`, and `CRITICAL_VALID` pulses on the following cycle.
  - After beat `BLOCK_WORDS-1`, go to FILL.
- **FILL:** `FILL_VALID`=1 with `FILL_LINE` and `FILL_ADDRESS` stable. On `FILL_READY`, go to IDLE.

Boundary and corner cases:
- `MISS_VALID` outside IDLE is ignored (`MISS_READY`=0); the request must be held by the cache.
- `DATA_FROM_L2_VALID` outside DATA is ignored (ready low); no beat is lost or counted.
- A valid beat while `ADDRESS_TO_L2_VALID` is still waiting for ready is not accepted.
- `FILL_READY` outside FILL has no effect.
- `RST` asserted in any state aborts immediately:
  - the FSM goes to IDLE;
  - the counter, line buffer, registered addresses and all outputs clear;
  - a burst interrupted by reset is not resumed, and L2 beats after reset are not acknowledged.

## Timing
Reset values: `MISS_READY`=1; every other output is 0, including `FILL_LINE`, `CRITICAL_WORD` and `ADDRESS_TO_L2`.

- All outputs are registered or decoded from registered state; there is no combinational path from `MISS_VALID`, `DATA_FROM_L2_*` or `FILL_READY` to any output.
- Miss accepted at edge N → `ADDRESS_TO_L2_VALID` high from cycle N+1.
- Address handshake at edge A → `DATA_FROM_L2_READY` high from cycle A+1.
- Beat accepted at edge B → `CRITICAL_VALID` high for exactly cycle B+1 (if it is the critical beat).
- Last beat accepted at edge L → `FILL_VALID` high from cycle L+1.
- Fill handshake at edge F → `MISS_READY` high from cycle F+1.
- Best-case miss-to-fill latency with zero-wait L2: `BLOCK_WORDS`+2 cycles.
- A new miss is accepted no earlier than the cycle after the fill handshake; there is no overlap between lines.

## Configuration
Macro: `L1_REFILL_CRITICAL_WORD_FIRST_EN`.
- **Defined:** `ADDRESS_TO_L2` = `MISS_ADDRESS`. L2 returns wrapping beats starting at the missed word, so `CRITICAL_VALID` follows the first beat.
- **Undefined:** `ADDRESS_TO_L2` = line base and the start index = 0. Beats arrive in sequential order, and `CRITICAL_VALID` fires after beat number (critical index).

`FILL_LINE` contents and ordering are identical in both builds.

## Test plan
- **Reset:** assert `RST` mid-DATA after 3 of 8 beats → `BUSY`=0, `FILL_LINE`=0 and `MISS_READY`=1 immediately; the next miss refills correctly.
- **Zero-wait miss:** `MISS_ADDRESS`=0x00000013, L2 always ready, beats 0xA0..0xA7.
  - With the macro: address issued is 0x13; line words [0..7] = {A5,A6,A7,A0,A1,A2,A3,A4}; `CRITICAL_WORD`=0xA0 one cycle after the first beat; `FILL_VALID` 10 cycles after the miss handshake.
  - Without the macro: address issued is 0x10; `CRITICAL_WORD`=0xA3.
- **Backpressure:** `ADDRESS_TO_L2_READY` held low 5 cycles, then `DATA_FROM_L2_VALID` toggled 1/0 → address stays stable; only valid beats are counted; `FILL_VALID` rises after the 8th valid beat.
- **Fill stall:** `FILL_READY` low 4 cycles → `FILL_LINE` and `FILL_ADDRESS` stable; `MISS_VALID` asserted meanwhile is not accepted until the cycle after `FILL_READY`.
- **Spurious data:** `DATA_FROM_L2_VALID`=1 with data 0xDEAD in IDLE and ADDR → `DATA_FROM_L2_READY`=0 and the line buffer is unchanged.
- **Wrap at the top of the address space:** `MISS_ADDRESS`=0x3FFFFFFF → `FILL_ADDRESS`=0x3FFFFFF8 and the critical index is 7.
